countdown_timer: RTL and testbench

Game countdown timer: loads a two-digit BCD seconds value and decrements it once per second to 00, then flags expiry to the game controller. It is the down-counting counterpart of the elapsed-time display counter. Its BCD digit outputs drive the HEX0/HEX1 decoders directly, and its expiry signals end the round.

---
 rtl/game_timer_pkg.sv | 23 ++
 rtl/second_tick_gen.sv | 44 ++++
 rtl/countdown_timer.sv | 157 +++++++++++++++
 tb/tb_countdown_timer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game timer blocks.
//   bcd_digit_t   : one BCD digit (0..9 valid)
//   timer_state_t : countdown FSM states
//   BCD_MAX       : largest legal BCD digit
//   bcd_sat()     : clamps a nibble to a legal BCD digit
package game_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_sat(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : bcd_digit_t'(v);
  endfunction

endpackage

// File: rtl/second_tick_gen.sv
// One-second tick divider for the countdown timer.
// Counts enabled cycles 0..CLOCK_FREQUENCY-1 and wraps; Tick is high for
// the one enabled cycle in which the count sits at the terminal value.
// Ports:
//   ClockIn  in  system clock
//   Resetn   in  async active-low reset
//   Clear    in  synchronous clear of the count (wins over Enable)
//   Enable   in  count this cycle; when low the count holds
//   Tick     out one-cycle strobe at terminal count
module second_tick_gen #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic ClockIn,
  input  logic Resetn,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam int DW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [DW-1:0] TC = DW'(CLOCK_FREQUENCY - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (Clear) begin
      div_d = '0;
    end else if (Enable) begin
      div_d = (div_q == TC) ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign Tick = Enable && (div_q == TC);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD game countdown timer.
// Loads a BCD seconds value, decrements it once per CLOCK_FREQUENCY running
// cycles down to 00 and then flags expiry. All outputs are registered.
// Optional feature macro: TIMER_WARN_EN (low-time Warn output). Without it
// Warn is tied low.
// Ports:
//   ClockIn, Resetn         clock, async active-low reset
//   Load, LoadTens/LoadOnes load strobe and BCD value (nibbles >9 clamp to 9)
//   Start, Pause            start/resume and freeze strobes
//   TensValue, OnesValue    remaining time, BCD digits
//   Running, Expired        state flags
//   ExpiredPulse            one-cycle strobe on entering EXPIRED
//   Warn                    low-time warning
//
// state   | meaning
// IDLE    | loaded, waiting for Start; divider cleared
// RUN     | counting; divider enabled
// PAUSED  | frozen; divider holds its partial count
// EXPIRED | reached 00; holds until Load
module countdown_timer
  import game_timer_pkg::*;
#(
  parameter int         CLOCK_FREQUENCY = 50000000,
  parameter bcd_digit_t START_TENS      = 4'd6,
  parameter bcd_digit_t START_ONES      = 4'd0,
  parameter int         WARN_SECONDS    = 10
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [3:0] LoadTens,
  input  logic [3:0] LoadOnes,
  input  logic       Start,
  input  logic       Pause,
  output logic [3:0] TensValue,
  output logic [3:0] OnesValue,
  output logic       Running,
  output logic       Expired,
  output logic       ExpiredPulse,
  output logic       Warn
);

  timer_state_t state_q, state_d;
  bcd_digit_t   tens_q, tens_d, ones_q, ones_d;
  logic         running_q, expired_q, pulse_q;
  logic         tick, div_clear, div_enable;

  assign div_enable = (state_q == RUN);

  second_tick_gen #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY)) u_tick (
    .ClockIn (ClockIn),
    .Resetn  (Resetn),
    .Clear   (div_clear),
    .Enable  (div_enable),
    .Tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    div_clear = 1'b0;
    if (Load) begin
      tens_d    = bcd_sat(LoadTens);
      ones_d    = bcd_sat(LoadOnes);
      state_d   = IDLE;
      div_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (tens_q == 4'd0 && ones_q == 4'd0) begin
              state_d = EXPIRED;
            end else begin
              state_d   = RUN;
              div_clear = 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              ones_d = BCD_MAX;
              tens_d = tens_q - 4'd1;
            end
          end
          // Reaching 00 takes precedence over a simultaneous Pause.
          if (tick && tens_d == 4'd0 && ones_d == 4'd0) begin
            state_d = EXPIRED;
          end else if (Pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (Start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      tens_q    <= START_TENS;
      ones_q    <= START_ONES;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
      pulse_q   <= (state_d == EXPIRED) && (state_q != EXPIRED);
    end
  end

  assign TensValue    = tens_q;
  assign OnesValue    = ones_q;
  assign Running      = running_q;
  assign Expired      = expired_q;
  assign ExpiredPulse = pulse_q;

`ifdef TIMER_WARN_EN
  logic       warn_q, warn_d;
  logic [6:0] secs_d;

  assign secs_d = 7'(tens_d) * 7'd10 + 7'(ones_d);

  always_comb begin
    warn_d = ((state_d == RUN) || (state_d == PAUSED)) &&
             (int'(secs_d) <= WARN_SECONDS);
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign Warn = warn_q;
`else
  logic unused_warn_cfg;
  assign unused_warn_cfg = (WARN_SECONDS != 0);
  assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int CF = 4;
  localparam int WARN_S = 10;
`ifdef TIMER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic       clk, rst_n;
  logic       load, start, pause;
  logic [3:0] load_tens, load_ones;
  logic [3:0] tens, ones;
  logic       running, expired, exp_pulse, warn;

  int total = 0;
  int bad   = 0;

  countdown_timer #(
    .CLOCK_FREQUENCY(CF),
    .START_TENS(4'd6),
    .START_ONES(4'd0),
    .WARN_SECONDS(WARN_S)
  ) dut (
    .ClockIn      (clk),
    .Resetn       (rst_n),
    .Load         (load),
    .LoadTens     (load_tens),
    .LoadOnes     (load_ones),
    .Start        (start),
    .Pause        (pause),
    .TensValue    (tens),
    .OnesValue    (ones),
    .Running      (running),
    .Expired      (expired),
    .ExpiredPulse (exp_pulse),
    .Warn         (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining time as plain seconds, mode as the
  // documented timer state, plus RUN cycles elapsed in the current second.
  int m_mode, m_secs, m_rc;
  bit m_pulse;

  always @(posedge clk or negedge rst_n) begin : model
    int md, s, rc, prev;
    bit p;
    if (!rst_n) begin
      m_mode  <= M_IDLE;
      m_secs  <= 60;
      m_rc    <= 0;
      m_pulse <= 1'b0;
    end else begin
      md = m_mode; s = m_secs; rc = m_rc; prev = m_mode;
      if (load) begin
        s  = 10 * ((load_tens > 9) ? 9 : int'(load_tens)) +
                  ((load_ones > 9) ? 9 : int'(load_ones));
        md = M_IDLE;
        rc = 0;
      end else if (md == M_IDLE) begin
        if (start) begin
          if (s == 0) md = M_EXP;
          else begin md = M_RUN; rc = 0; end
        end
      end else if (md == M_RUN) begin
        rc = rc + 1;
        if (rc == CF) begin
          rc = 0;
          if (s > 0) s = s - 1;
          if (s == 0) md = M_EXP;
          else if (pause) md = M_PAUSED;
        end else if (pause) begin
          md = M_PAUSED;
        end
      end else if (md == M_PAUSED) begin
        if (start) md = M_RUN;
      end
      p = (md == M_EXP) && (prev != M_EXP);
      m_mode  <= md;
      m_secs  <= s;
      m_rc    <= rc;
      m_pulse <= p;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model tens",    int'(tens),      m_secs / 10);
      chk("model ones",    int'(ones),      m_secs % 10);
      chk("model running", int'(running),   int'(m_mode == M_RUN));
      chk("model expired", int'(expired),   int'(m_mode == M_EXP));
      chk("model pulse",   int'(exp_pulse), int'(m_pulse));
      chk("model warn",    int'(warn),
          int'(WARN_EN && (m_mode == M_RUN || m_mode == M_PAUSED) && m_secs <= WARN_S));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int t, input int o);
    load = 1'b1; load_tens = 4'(t); load_ones = 4'(o);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic chk_digits(input string name, input int t, input int o);
    chk({name, " tens"}, int'(tens), t);
    chk({name, " ones"}, int'(ones), o);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_tens = '0; load_ones = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk_digits("reset", 6, 0);
    chk("reset running", int'(running), 0);
    chk("reset expired", int'(expired), 0);
    chk("reset pulse",   int'(exp_pulse), 0);
    chk("reset warn",    int'(warn), 0);

    do_start();
    chk("start running", int'(running), 1);
    step(3); chk_digits("before first tick", 6, 0);
    step(1); chk_digits("first tick", 5, 9);
    step(4); chk_digits("second tick", 5, 8);

    do_load(0, 2);
    chk_digits("load 02", 0, 2);
    chk("load idle", int'(running), 0);
    do_start();
    step(4); chk_digits("02 tick1", 0, 1);
    step(3); chk("pre expiry", int'(expired), 0);
    step(1);
    chk_digits("expiry", 0, 0);
    chk("expiry expired", int'(expired), 1);
    chk("expiry pulse",   int'(exp_pulse), 1);
    chk("expiry running", int'(running), 0);
    step(1); chk("pulse one cycle", int'(exp_pulse), 0);
    do_start();
    chk("start in expired", int'(expired), 1);
    chk_digits("expired hold", 0, 0);

    do_load(3, 0);
    do_start();
    step(1);
    do_pause();
    chk("paused running", int'(running), 0);
    step(10); chk_digits("paused hold", 3, 0);
    do_start();
    step(1); chk_digits("resume 1", 3, 0);
    step(1); chk_digits("resume tick", 2, 9);

    do_load(0, 0);
    do_start();
    chk("load00 expired", int'(expired), 1);
    chk("load00 pulse",   int'(exp_pulse), 1);

    do_load(15, 12);
    chk_digits("saturate", 9, 9);
    do_start();
    step(2);
    do_load(1, 2);
    chk_digits("load in run", 1, 2);
    chk("load in run idle", int'(running), 0);
    do_start();
    step(3);
    do_pause();
    chk_digits("tick+pause", 1, 1);
    chk("tick+pause running", int'(running), 0);
    step(8); chk_digits("tick+pause hold", 1, 1);

    do_load(1, 1);
    do_start();
    chk("warn at 11", int'(warn), 0);
    step(4);
    chk_digits("warn digits", 1, 0);
    chk("warn at 10", int'(warn), int'(WARN_EN));

    do_load(2, 5);
    do_start();
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_digits("async reset", 6, 0);
    chk("async reset running", int'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 5) == 0);
      pause = ($urandom_range(0, 9) == 0);
      load_tens = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 2));
      load_ones = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
